dvid_timing_ctrl: RTL

Video timing controller that sequences the DVI-D output path: generates 640x480@60 raster timing on the 25 MHz pixel clock, issues pixel fetch requests to the frame source ahead of display, and realigns hsync/vsync/blank with the returned pixel data before it enters the TMDS encoder. It also holds the raster idle until the serializer clocking reports lock. It sits between the game video memory and the DVI-D output module.

---
 rtl/dvid_timing_pkg.sv | 15 +
 rtl/dvid_sync_delay.sv | 20 ++
 rtl/dvid_timing_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dvid_timing_pkg.sv
// dvid_timing_pkg: raster state encoding and default 640x480@60 timing constants.
package dvid_timing_pkg;
  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_SETTLE, ST_RUN} state_e;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/dvid_sync_delay.sv
// dvid_sync_delay: DEPTH-stage shift register whose every stage can be synchronously
// reloaded with FLUSH_VAL, so no stale control bits survive a raster stop.
module dvid_sync_delay #(
  parameter int DEPTH = 2,
  parameter int W = 4,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH*W-1:0] sr_q, sr_d;
  assign sr_d = flush_i ? {DEPTH{FLUSH_VAL}} : (DEPTH*W)'({sr_q, d_i});
  assign q_o = sr_q[DEPTH*W-1 -: W];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sr_q <= {DEPTH{FLUSH_VAL}};
    else sr_q <= sr_d;
endmodule

// File: rtl/dvid_timing_ctrl.sv
// dvid_timing_ctrl: raster timing, pixel fetch requests and sync/blank realignment for DVI-D.
// Define DVID_TIMING_TESTPAT_EN to build the 8-bar test pattern selected by test_en.
module dvid_timing_ctrl
  import dvid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int FETCH_LAT = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int SETTLE = 16
) (
  input  logic       clk_vga,
  input  logic       reset,
  input  logic       locked,
  input  logic       test_en,
  input  logic [7:0] pix_red,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_blue,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("dvid_timing_ctrl: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (FETCH_LAT < 1 || FETCH_LAT > 8 || SETTLE < 1) begin : g_bad_cfg
    $error("dvid_timing_ctrl: FETCH_LAT must be 1..8 and SETTLE at least 1");
  end

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lk_meta_q, lk_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic run, adv, hs, vs, fs, hs_t, vs_t, bl_t, fs_t;
  logic [7:0] px_r, px_g, px_b;
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic hs_q, hs_d, vs_q, vs_d, bl_q, bl_d, fs_q, fs_d;

  // The WAIT_LOCK cycle that first sees lk counts as the first stable cycle.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: if (lk_q) begin
        state_d = SETTLE > 1 ? ST_SETTLE : ST_RUN;
        cnt_d = CW'(1);
      end
      ST_SETTLE: begin
        state_d = !lk_q ? ST_WAIT_LOCK : (cnt_q == SETTLE_LAST ? ST_RUN : ST_SETTLE);
        cnt_d = cnt_q + CW'(1);
      end
      ST_RUN: state_d = lk_q ? ST_RUN : ST_WAIT_LOCK;
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  assign run = state_q == ST_RUN;
  assign adv = run && lk_q;
  assign h_d = (!adv || h_q == H_LAST) ? '0 : h_q + 10'd1;
  assign v_d = !adv ? '0 : (h_q != H_LAST ? v_q : (v_q == V_LAST ? '0 : v_q + 10'd1));
  assign pix_req = run && ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
  assign pix_x = pix_req ? h_q : '0;
  assign pix_y = pix_req ? v_q : '0;
  assign hs = run && {1'b0, h_q} >= HS_BEG && {1'b0, h_q} < HS_END;
  assign vs = run && {1'b0, v_q} >= VS_BEG && {1'b0, v_q} < VS_END;
  assign fs = run && h_q == '0 && v_q == '0;

  dvid_sync_delay #(
    .DEPTH(FETCH_LAT),
    .W(4),
    .FLUSH_VAL(4'b0010)
  ) u_sync_delay (
    .clk_i(clk_vga),
    .rst_i(reset),
    .flush_i(!run),
    .d_i({hs, vs, !pix_req, fs}),
    .q_o({hs_t, vs_t, bl_t, fs_t})
  );

`ifdef DVID_TIMING_TESTPAT_EN
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);
  logic [9:0] pcnt_q, pcnt_d;
  logic [2:0] bar_q, bar_d;
  // Bars are counted on the realigned stream, so blanking restarts them every line.
  always_comb begin
    pcnt_d = (!run || bl_t || pcnt_q == BAR_LAST) ? '0 : pcnt_q + 10'd1;
    bar_d = (!run || bl_t) ? '0 : (pcnt_q == BAR_LAST ? bar_q + 3'd1 : bar_q);
    px_r = test_en ? {8{~bar_q[2]}} : pix_red;
    px_g = test_en ? {8{~bar_q[1]}} : pix_green;
    px_b = test_en ? {8{~bar_q[0]}} : pix_blue;
  end
  always_ff @(posedge clk_vga or posedge reset)
    if (reset) begin
      pcnt_q <= '0;
      bar_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      bar_q <= bar_d;
    end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign px_r = pix_red;
  assign px_g = pix_green;
  assign px_b = pix_blue;
`endif

  always_comb begin
    red_d = (!run || bl_t) ? '0 : px_r;
    green_d = (!run || bl_t) ? '0 : px_g;
    blue_d = (!run || bl_t) ? '0 : px_b;
    hs_d = run && hs_t;
    vs_d = run && vs_t;
    bl_d = !run || bl_t;
    fs_d = run && fs_t;
  end

  always_ff @(posedge clk_vga or posedge reset)
    if (reset) begin
      lk_meta_q <= 1'b0;
      lk_q <= 1'b0;
      state_q <= ST_WAIT_LOCK;
      cnt_q <= '0;
      h_q <= '0;
      v_q <= '0;
      red_q <= '0;
      green_q <= '0;
      blue_q <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      bl_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_q <= lk_meta_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      h_q <= h_d;
      v_q <= v_d;
      red_q <= red_d;
      green_q <= green_d;
      blue_q <= blue_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      bl_q <= bl_d;
      fs_q <= fs_d;
    end

  assign red = red_q;
  assign green = green_q;
  assign blue = blue_q;
  assign hsync = hs_q ~^ SYNC_POL;
  assign vsync = vs_q ~^ SYNC_POL;
  assign blank = bl_q;
  assign frame_start = fs_q;
endmodule
